// File: rtl/pwm_fade_ctrl.sv
// Fade sequencer for one pwm8 channel: ramps duty_cycle toward a commanded target,
// updating only at PWM frame boundaries. Define CMD_PREEMPT_EN to let commands redirect a fade.
module pwm_fade_ctrl #(
  parameter int FRAMES_PER_STEP = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_target,
  input  logic [3:0] cmd_step,
  output logic [7:0] duty_cycle,
  output logic       pwm_rst,
  output logic       frame_tick,
  output logic       busy,
  output logic       done
);

  localparam int DIV_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAMES_PER_STEP - 1);

  typedef enum logic [1:0] {IDLE, UP, DOWN, JUMP} state_t;

  state_t           state, state_nx;
  logic [7:0]       frame_cnt;
  logic [DIV_W-1:0] div;
  logic [7:0]       target, target_nx;
  logic [3:0]       step, step_nx;
  logic [7:0]       duty_nx;
  logic             done_nx;
  logic             accept;
  logic             step_due;
  logic [8:0]       gap_up, gap_dn, step_ext;

`ifdef CMD_PREEMPT_EN
  assign cmd_ready = 1'b1;
`else
  assign cmd_ready = (state == IDLE);
`endif

  assign accept     = cmd_valid & cmd_ready;
  assign frame_tick = (frame_cnt == 8'd255);
  assign step_due   = frame_tick && (div == DIV_LAST);
  assign busy       = (state != IDLE);

  // 9-bit distances to the target make the clamp decision immune to wrap-around.
  assign gap_up   = {1'b0, target} - {1'b0, duty_cycle};
  assign gap_dn   = {1'b0, duty_cycle} - {1'b0, target};
  assign step_ext = {5'b0, step};

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_nx  = state;
    target_nx = target;
    step_nx   = step;
    duty_nx   = duty_cycle;
    done_nx   = 1'b0;
    if (accept) begin
      target_nx = cmd_target;
      step_nx   = cmd_step;
      if (cmd_target == duty_cycle) begin
        state_nx = IDLE;
        done_nx  = 1'b1;
      end else if (cmd_step == 4'd0) begin
        state_nx = JUMP;
      end else if (cmd_target > duty_cycle) begin
        state_nx = UP;
      end else begin
        state_nx = DOWN;
      end
    end else begin
      case (state)
        JUMP: begin
          if (frame_tick) begin
            duty_nx  = target;
            done_nx  = 1'b1;
            state_nx = IDLE;
          end
        end
        UP: begin
          if (step_due) begin
            if (gap_up <= step_ext) begin
              duty_nx  = target;
              done_nx  = 1'b1;
              state_nx = IDLE;
            end else begin
              duty_nx = duty_cycle + {4'b0, step};
            end
          end
        end
        DOWN: begin
          if (step_due) begin
            if (gap_dn <= step_ext) begin
              duty_nx  = target;
              done_nx  = 1'b1;
              state_nx = IDLE;
            end else begin
              duty_nx = duty_cycle - {4'b0, step};
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
    if (!rst_n) begin
      state      <= IDLE;
      duty_cycle <= 8'd0;
      pwm_rst    <= 1'b1;
      frame_cnt  <= 8'd0;
      div        <= '0;
      target     <= 8'd0;
      step       <= 4'd0;
      done       <= 1'b0;
    end else begin
      state      <= state_nx;
      duty_cycle <= duty_nx;
      target     <= target_nx;
      step       <= step_nx;
      done       <= done_nx;
      pwm_rst    <= 1'b0;
      // Mirrors pwm8's counter, which is held at zero while its reset is asserted.
      frame_cnt  <= pwm_rst ? 8'd0 : frame_cnt + 8'd1;
      if (accept) begin
        div <= '0;
      end else if (frame_tick) begin
        div <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
      end
    end
  end

endmodule
